// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        FILL,
        COMMIT
    } state_t;

    localparam logic [31:0] INSTR_ZERO = 32'h0;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag takes whatever is left above word offset, line index and byte offset.
    function automatic int tag_w(input int num_lines, input int line_words);
        return 32 - 2 - off_w(line_words) - idx_w(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag and data storage: asynchronous read port, one word-write port and one tag-write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = idx_w(64),
    parameter int OFF_W      = off_w(4),
    parameter int TAG_W      = tag_w(64, 4)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [31:0]       word_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_idx,
    input  logic [TAG_W-1:0]  tag_data
);

    logic [TAG_W-1:0] tags  [NUM_LINES];
    logic [31:0]      words [NUM_LINES][LINE_WORDS];

    // No reset: contents are only trusted behind the valid bits held by the parent.
    always_ff @(posedge clk) begin
        if (word_we) begin
            words[word_idx][word_off] <= word_data;
        end
        if (tag_we) begin
            tags[tag_idx] <= tag_data;
        end
    end

    assign rd_tag  = tags[rd_idx];
    assign rd_data = words[rd_idx][rd_off];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hits, line refill FSM on miss.
module icache_responder
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] program_counter_address,
    output logic [31:0] instruction,
    output logic        instruction_grant,
    input  logic        invalidate_all,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS);
    localparam int IDX_LO = OFF_W + 2;
    localparam int TAG_LO = OFF_W + IDX_W + 2;

    state_t state, next_state;

    logic [NUM_LINES-1:0] valid;
    logic [31:0]          line_addr;
    logic [OFF_W-1:0]     beat;
    logic                 kill_pending;

    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_off;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             tag_match;
    logic             hit;
    logic             miss;
    logic             last_beat;
    logic             unused_pc_bits;

    assign pc_idx         = program_counter_address[TAG_LO-1:IDX_LO];
    assign pc_off         = program_counter_address[IDX_LO-1:2];
    assign pc_tag         = program_counter_address[31:TAG_LO];
    assign fill_idx       = line_addr[TAG_LO-1:IDX_LO];
    assign fill_tag       = line_addr[31:TAG_LO];
    assign unused_pc_bits = ^program_counter_address[1:0];

    assign tag_match = valid[pc_idx] && (rd_tag == pc_tag);
    assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));

    icache_line_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rd_idx    (pc_idx),
        .rd_off    (pc_off),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   ((state == FILL) && mem_resp_valid),
        .word_idx  (fill_idx),
        .word_off  (beat),
        .word_data (mem_resp_data),
        .tag_we    (state == COMMIT),
        .tag_idx   (fill_idx),
        .tag_data  (fill_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        hit               = 1'b0;
        miss              = 1'b0;
        instruction_grant = 1'b0;
        instruction       = INSTR_ZERO;
        mem_req_valid     = 1'b0;
        mem_req_address   = line_addr;
        case (state)
            IDLE: begin
                hit  = tag_match && !invalidate_all;
                miss = !tag_match && !invalidate_all;
                instruction_grant = hit;
                if (hit) begin
                    instruction = rd_data;
                end
                if (miss) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (mem_resp_valid && last_beat) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= '0;
            line_addr    <= '0;
            beat         <= '0;
            kill_pending <= 1'b0;
        end else begin
            // A bulk invalidate overrides both the miss-time clear and the commit-time set.
            if (invalidate_all) begin
                valid <= '0;
            end else if (miss) begin
                valid[pc_idx] <= 1'b0;
            end else if ((state == COMMIT) && !kill_pending) begin
                valid[fill_idx] <= 1'b1;
            end

            if (state == COMMIT) begin
                kill_pending <= 1'b0;
            end else if (invalidate_all && (state != IDLE)) begin
                kill_pending <= 1'b1;
            end

            if (miss) begin
                line_addr <= {program_counter_address[31:IDX_LO], {IDX_LO{1'b0}}};
            end

            if ((state == FILL) && mem_resp_valid) begin
                beat <= last_beat ? '0 : beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed plus randomized bench for icache_responder against a line-level cache/memory model.
module tb_icache_responder;

    localparam int NL = 64;
    localparam int LW = 4;
    localparam int LB = LW * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h100;
    logic [31:0] instruction;
    logic        instruction_grant;
    logic        invalidate_all = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;

    always #5 clk = ~clk;

    icache_responder #(
        .NUM_LINES  (NL),
        .LINE_WORDS (LW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .program_counter_address (pc),
        .instruction             (instruction),
        .instruction_grant       (instruction_grant),
        .invalidate_all          (invalidate_all),
        .mem_req_valid           (mem_req_valid),
        .mem_req_ready           (mem_req_ready),
        .mem_req_address         (mem_req_address),
        .mem_resp_valid          (mem_resp_valid),
        .mem_resp_data           (mem_resp_data)
    );

    int checks = 0;
    int errors = 0;

    // Model: which line address each index currently holds, plus backing memory.
    bit          valid_m [NL];
    logic [31:0] line_m  [NL];
    logic [31:0] mem     [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / LB) % NL);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % LB);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return valid_m[idx_of(a)] && (line_m[idx_of(a)] == line_of(a));
    endfunction

    task automatic clear_model();
        foreach (valid_m[i]) valid_m[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(output bit hit);
        logic [31:0] a;
        a = pc;
        hit = m_hit(a);
        #1;
        chk("grant", 32'(instruction_grant), 32'(hit));
        chk("instr", instruction, hit ? mem_rd({a[31:2], 2'b00}) : 32'h0);
    endtask

    // Entered in IDLE on a predicted miss; inval_at selects a FILL beat (0..LW-1) or COMMIT (LW).
    task automatic refill(input int waits, input bit junk, input bit gaps,
                          input int inval_at, input bit redirect, input logic [31:0] rpc);
        logic [31:0] line;
        int idx;
        bit kill;
        line = line_of(pc);
        idx  = idx_of(pc);
        kill = 1'b0;
        valid_m[idx] = 1'b0;
        step();
        for (int w = 0; w < waits; w++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = junk;
            mem_resp_data  = $urandom;
            #1;
            chk("req_valid_wait", 32'(mem_req_valid), 32'd1);
            chk("req_addr_wait", mem_req_address, line);
            chk("grant_req", 32'(instruction_grant), 32'd0);
            step();
        end
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_req_address, line);
        step();
        mem_req_ready = 1'b0;
        if (redirect) pc = rpc;
        #1;
        chk("req_drop", 32'(mem_req_valid), 32'd0);
        for (int b = 0; b < LW; b++) begin
            for (int g = 0; gaps && g < 3 && $urandom_range(0, 2) == 0; g++) begin
                mem_resp_valid = 1'b0;
                #1;
                chk("grant_gap", 32'(instruction_grant), 32'd0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_rd(line + 32'(4 * b));
            if (inval_at == b) begin
                invalidate_all = 1'b1;
                kill = 1'b1;
                clear_model();
            end
            #1;
            chk("grant_fill", 32'(instruction_grant), 32'd0);
            chk("instr_fill", instruction, 32'h0);
            step();
            invalidate_all = 1'b0;
        end
        mem_resp_valid = junk;
        mem_resp_data  = $urandom;
        if (inval_at == LW) begin
            invalidate_all = 1'b1;
            kill = 1'b1;
            clear_model();
        end
        #1;
        chk("grant_commit", 32'(instruction_grant), 32'd0);
        chk("req_commit", 32'(mem_req_valid), 32'd0);
        step();
        invalidate_all = 1'b0;
        mem_resp_valid = 1'b0;
        if (!kill) begin
            valid_m[idx] = 1'b1;
            line_m[idx]  = line;
        end
    endtask

    task automatic access(input logic [31:0] a, input int waits, input bit junk, input bit gaps,
                          input int inval_at, input bit redirect, input logic [31:0] rpc);
        bit hit;
        pc = a;
        for (int n = 0; n < 4; n++) begin
            check_fetch(hit);
            if (hit) begin
                step();
                return;
            end
            refill(waits, junk, gaps, (n == 0) ? inval_at : -1, (n == 0) ? redirect : 1'b0, rpc);
        end
        chk("access_settles", 32'(instruction_grant), 32'd1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t, i, w;
        int sel;
        t   = 32'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 3));
        i   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd16 : (sel == 2) ? 32'd32 : 32'd63;
        w   = 32'($urandom_range(0, LW - 1));
        return (t << 10) | (i << 4) | (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit hit;
        clear_model();
        mem[32'h100] = 32'h11;
        mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33;
        mem[32'h10C] = 32'h44;

        // Reset state.
        step();
        step();
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_address, 32'h0);
        chk("rst_grant", 32'(instruction_grant), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        rst_n = 1'b1;

        // Cold miss and zero-latency hits within the filled line.
        access(32'h100, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);
        chk("cold_word0", instruction, 32'h11);
        access(32'h104, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);
        access(32'h108, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);
        access(32'h10C, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // Conflict eviction on the same index.
        access(32'h500, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);
        access(32'h100, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // Backpressure with junk beats during REQUEST.
        access(32'h600, 5, 1'b1, 1'b0, -1, 1'b0, 32'h0);
        access(32'h604, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // Redirect to a cached PC during FILL, then the refilled line hits.
        access(32'h200, 0, 1'b0, 1'b0, -1, 1'b1, 32'h104);
        access(32'h208, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // invalidate_all during FILL and during COMMIT.
        access(32'h300, 0, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        access(32'h100, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);
        access(32'h400, 0, 1'b0, 1'b0, LW, 1'b0, 32'h0);

        // invalidate_all in IDLE forces grant low that cycle.
        pc = 32'h400;
        invalidate_all = 1'b1;
        #1;
        chk("inval_idle_grant", 32'(instruction_grant), 32'd0);
        chk("inval_idle_instr", instruction, 32'h0);
        step();
        invalidate_all = 1'b0;
        clear_model();
        access(32'h400, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // Asynchronous reset in the middle of FILL.
        pc = 32'h700;
        check_fetch(hit);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("arst_grant", 32'(instruction_grant), 32'd0);
        chk("arst_req_addr", mem_req_address, 32'h0);
        clear_model();
        step();
        mem_resp_valid = 1'b0;
        pc = 32'h100;
        rst_n = 1'b1;
        access(32'h100, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0);

        // Randomized traffic over a few conflicting indices.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                pc = rand_pc();
                invalidate_all = 1'b1;
                #1;
                chk("rnd_inval_grant", 32'(instruction_grant), 32'd0);
                step();
                invalidate_all = 1'b0;
                clear_model();
            end
            access(rand_pc(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, LW)) : -1,
                   ($urandom_range(0, 4) == 0), rand_pc());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache.
- Answers the fetch stage's PC-address / instruction / grant interface.
- Hits return an instruction combinationally in the same cycle.
- Misses drop grant and run a line-refill state machine against the memory bus.
- Sits between the core frontend and the shared memory interconnect.

Parameters:
NUM_LINES, 64, number of cache lines (power of two, >=2)
LINE_WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset
program_counter_address  input  32  fetch address from frontend; bits [1:0] ignored
instruction  output  32  fetched word; 32'h0 whenever instruction_grant=0
instruction_grant  output  1  instruction valid for current program_counter_address this cycle
invalidate_all  input  1  single-cycle pulse (fence.i) clearing all valid bits
mem_req_valid  output  1  line-refill request
mem_req_ready  input  1  interconnect accepts request
mem_req_address  output  32  line-aligned refill address
mem_resp_valid  input  1  one refill beat present
mem_resp_data  input  32  refill beat data, ascending word order from word 0

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset state: all valid bits 0, FSM in IDLE, beat counter 0, mem_req_valid=0, mem_req_address=0, instruction_grant=0, instruction=0.
- Address split:
  - OFF = log2(LINE_WORDS) word-select bits at [OFF+1:2].
  - IDX = log2(NUM_LINES) bits above OFF.
  - Tag is the remaining upper bits.
- Arrays: tag and data arrays are read asynchronously; valid bits are flops.
- Hit = IDLE && valid[idx] && tag[idx]==pc_tag && !invalidate_all.
- Hit response: grant=1, instruction=data[idx][word], zero latency.
- FSM states: IDLE, REQUEST, FILL, COMMIT.
  - IDLE: on miss (not hit and not invalidate_all), latch line address = {pc[31:OFF+2], zeros}, clear valid[idx], go to REQUEST.
  - REQUEST: mem_req_valid=1 with the latched address held stable. Leave to FILL on the cycle mem_req_valid && mem_req_ready; mem_req_valid deasserts the next cycle.
  - FILL: each mem_resp_valid beat writes data[idx][beat] and increments the beat counter. After beat LINE_WORDS-1, go to COMMIT. Beats arriving in IDLE, REQUEST or COMMIT are ignored.
  - COMMIT: write tag and set valid[idx], unless a kill is pending (see below). Return to IDLE. The earliest hit is the next cycle, so miss-to-grant latency = 1 (REQUEST min) + LINE_WORDS + 1 + 1 cycles.
- instruction_grant=0 in every state other than IDLE.
- PC change during a refill (frontend redirect): the refill always completes for the latched line; it is never cancelled. IDLE then re-evaluates the current PC.
- invalidate_all:
  - In IDLE: clear all valid bits next edge; grant forced 0 that cycle.
  - In REQUEST, FILL or COMMIT: clear all valid bits and set a kill-pending flop. COMMIT skips setting valid when kill is pending, then clears the flop.
  - In COMMIT the same cycle: invalidate wins; the line stays invalid.
- Beat counter wraps to 0 on leaving FILL.
- Reset mid-refill: FSM returns to IDLE and mem_req_valid drops immediately (async). Beats that arrive afterwards are ignored.
- Combinational path: program_counter_address to instruction/grant has no register stage. The frontend captures instruction the same cycle it drives the PC.

Decomposition:
- Shared package icache_pkg holds:
  - state enum (IDLE, REQUEST, FILL, COMMIT);
  - localparam helpers for OFF/IDX/TAG widths as functions of NUM_LINES and LINE_WORDS;
  - constant INSTR_ZERO = 32'h0.
- Sub-module icache_line_array holds the tag and data storage with an async read port and one word-write port plus a tag-write port. Valid bits stay in the top level, because invalidate_all is a bulk clear.

Test Plan:
- Cold miss: PC=0x0000_0100 after reset. Expect grant=0, REQUEST with mem_req_address=0x100; with ready=1 and beats 0x11,0x22,0x33,0x44 on consecutive cycles, grant=1 and instruction=0x11 on the cycle after COMMIT. PC 0x104/0x108/0x10C then return 0x22/0x33/0x44 with zero latency.
- Conflict eviction: fill line 0x100, then PC=0x0000_0500 (same index, NUM_LINES=64, LINE_WORDS=4). Expect a miss and refill at 0x500. A subsequent PC=0x100 misses again.
- Backpressure: hold mem_req_ready=0 for 5 cycles. Expect mem_req_valid and mem_req_address stable throughout; FILL is entered only after the ready cycle. Beats driven during REQUEST are ignored, with no data-array write.
- Redirect mid-refill: miss at 0x200, change PC to 0x100 (cached) during FILL. Expect grant=0 until COMMIT completes line 0x200; the next cycle grant=1 for 0x100. A later PC=0x200 hits.
- invalidate_all during FILL of 0x300: expect COMMIT leaves line 0x300 invalid and all prior lines invalid. PC=0x300 misses again.
- Async reset asserted in FILL: expect mem_req_valid=0, grant=0 immediately. After release, PC=0x100 misses.
